// File: rtl/mcu_ctrl_mw.sv
// Multicycle control FSM for the bus-based MIPS datapath: registered control word,
// memory wait-state handshake with timeout, trap on illegal opcode/timeout, retire counter.
module mcu_ctrl_mw #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OPC_R    = 6'h00,
  parameter logic [OP_W-1:0] OPC_J    = 6'h02,
  parameter logic [OP_W-1:0] OPC_BEQ  = 6'h04,
  parameter logic [OP_W-1:0] OPC_BNE  = 6'h05,
  parameter logic [OP_W-1:0] OPC_ADDI = 6'h08,
  parameter logic [OP_W-1:0] OPC_LW   = 6'h23,
  parameter logic [OP_W-1:0] OPC_SW   = 6'h2B,
  parameter int              TMO      = 15,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  inst,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic [23:0]      ctrl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [4:0]       state_dbg
);

  typedef enum logic [4:0] {
    S_RST, FETCH0, FETCH1, INC, DECODE, LW_A, SW_A, AI_EX, LW_M, SW_M, LW_RD,
    LW_WB, SW_D, SW_WR, R_EX, R_WB, AI_WB, BR_CMP, BR_T, BR_W, JMP, TRAP
  } state_t;

  localparam logic [23:0] PCSRC = 24'h1 << 0,  PCOE  = 24'h1 << 1,  PCWR   = 24'h1 << 2;
  localparam logic [23:0] AWR   = 24'h1 << 3,  AOE   = 24'h1 << 4,  IRWR   = 24'h1 << 5;
  localparam logic [23:0] IMMOE = 24'h1 << 6,  REGWR = 24'h1 << 7,  REG1OE = 24'h1 << 8;
  localparam logic [23:0] REG2OE = 24'h1 << 9, GOE   = 24'h1 << 10, DIR    = 24'h1 << 11;
  localparam logic [23:0] MEMOE = 24'h1 << 12, MDRSRC = 24'h1 << 13, MDROE = 24'h1 << 14;
  localparam logic [23:0] MDRWR = 24'h1 << 15, MEMRD = 24'h1 << 16, MEMWR  = 24'h1 << 17;
  localparam logic [23:0] MARWR = 24'h1 << 18, REGDST = 24'h1 << 19;
  localparam logic [23:0] ALU01 = 24'h1 << 20, ALU10 = 24'h2 << 20;
  localparam logic [23:0] EXT01 = 24'h1 << 22, EXT10 = 24'h2 << 22, EXT11 = 24'h3 << 22;
  localparam logic [7:0]  TMO_C = 8'(TMO);

  state_t     state, nxt;
  logic [7:0] waitCnt;
  logic       isBne, isWait;

  function automatic logic [23:0] word(input state_t s);
    case (s)
      FETCH0:             return PCOE | MARWR | GOE | DIR;
      FETCH1:             return MEMRD | MEMOE | IRWR;
      INC:                return PCOE | IMMOE | EXT10 | AWR;
      DECODE, BR_W:       return AOE | PCSRC | PCOE | PCWR;
      LW_A, SW_A, AI_EX:  return REG1OE | IMMOE | AWR;
      LW_M, SW_M:         return AOE | MARWR;
      LW_RD:              return MEMRD | MDRSRC | MDRWR;
      LW_WB:              return MDROE | GOE | DIR | REGWR;
      SW_D:               return REG2OE | GOE | MDRWR;
      SW_WR:              return MEMWR;
      R_EX:               return REG1OE | REG2OE | ALU01 | AWR;
      R_WB:               return AOE | REGWR | REGDST;
      AI_WB:              return AOE | REGWR;
      BR_CMP:             return REG1OE | REG2OE | ALU10;
      BR_T:               return PCOE | IMMOE | EXT01 | AWR;
      JMP:                return IMMOE | EXT11 | PCOE | PCWR;
      default:            return 24'h0;
    endcase
  endfunction

  assign isWait    = (state == FETCH1) || (state == LW_RD) || (state == SW_WR);
  assign state_dbg = state;

  // Next-state selection; wait states stall until ready, ready beats the timeout.
  always_comb begin
    nxt = state;
    case (state)
      S_RST:  nxt = FETCH0;
      FETCH0: nxt = FETCH1;
      FETCH1: nxt = mem_ready ? INC : ((waitCnt == TMO_C) ? TRAP : FETCH1);
      INC:    nxt = DECODE;
      DECODE: begin
        if (inst == OPC_LW)                         nxt = LW_A;
        else if (inst == OPC_SW)                    nxt = SW_A;
        else if (inst == OPC_R)                     nxt = R_EX;
        else if (inst == OPC_ADDI)                  nxt = AI_EX;
        else if (inst == OPC_BEQ || inst == OPC_BNE) nxt = BR_CMP;
        else if (inst == OPC_J)                     nxt = JMP;
        else                                        nxt = TRAP;
      end
      LW_A:   nxt = LW_M;
      SW_A:   nxt = SW_M;
      AI_EX:  nxt = AI_WB;
      LW_M:   nxt = LW_RD;
      SW_M:   nxt = SW_D;
      LW_RD:  nxt = mem_ready ? LW_WB : ((waitCnt == TMO_C) ? TRAP : LW_RD);
      LW_WB:  nxt = FETCH0;
      SW_D:   nxt = SW_WR;
      SW_WR:  nxt = mem_ready ? FETCH0 : ((waitCnt == TMO_C) ? TRAP : SW_WR);
      R_EX:   nxt = R_WB;
      R_WB:   nxt = FETCH0;
      AI_WB:  nxt = FETCH0;
      BR_CMP: nxt = (isBne ? ~Zero : Zero) ? BR_T : FETCH0;
      BR_T:   nxt = BR_W;
      BR_W:   nxt = FETCH0;
      JMP:    nxt = FETCH0;
      TRAP:   nxt = TRAP;
      default: nxt = S_RST;
    endcase
  end

  // Every return to FETCH0 (other than out of reset) completes an instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RST;
      ctrl       <= 24'h0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      retired    <= '0;
      waitCnt    <= 8'h0;
      isBne      <= 1'b0;
    end else begin
      state <= nxt;
      ctrl  <= word(nxt);
      if (isWait && !mem_ready && nxt == state) waitCnt <= waitCnt + 8'h1;
      else                                      waitCnt <= 8'h0;
      if (nxt == FETCH0 && state != S_RST) retired <= retired + CNT_W'(1);
      if (nxt == TRAP && state != TRAP) begin
        trap       <= 1'b1;
        trap_cause <= (state == DECODE) ? 2'b01 : 2'b10;
      end
      if (state == DECODE) isBne <= (inst == OPC_BNE);
    end
  end

endmodule
